// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-bus arbiter between
// instruction fetch and the load/store unit.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker: bit 0 is instruction fetch, bit 1 is data.
// On a tie the port that did not win last time gets the grant.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       owner_o
);

    always_comb begin
        valid_o = |req_i;
        owner_o = OWN_INSTR;
        case (req_i)
            2'b01:   owner_o = OWN_INSTR;
            2'b10:   owner_o = OWN_DATA;
            2'b11:   owner_o = ~last_grant_i;
            default: owner_o = OWN_INSTR;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memcontrol bus port between fetch and load/store: grant, latch,
// strobe, wait for the bus (with timeout), then a one-cycle ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_ack,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_read,
    output logic              bus_write,
    input  logic              bus_busy,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              grant_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_grant_q;
    logic              we_q;
    logic              err_pend_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              bus_read_q;
    logic              bus_write_q;
    logic              instr_ack_q;
    logic              data_ack_q;
    logic              err_q;
    logic [DATA_W-1:0] instr_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;

    logic   pick_valid;
    logic   pick_owner_raw;
    owner_t pick_owner;

    mem_arb_rr_pick u_pick (
        .req_i        ({data_req, instr_req}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .owner_o      (pick_owner_raw)
    );

    assign pick_owner = owner_t'(pick_owner_raw);

    always_comb begin
        cnt_d = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Strobes, acks and err default low so every pulse lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_INSTR;
            last_grant_q  <= OWN_INSTR;
            we_q          <= 1'b0;
            err_pend_q    <= 1'b0;
            cnt_q         <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            instr_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            err_q         <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_owner;
                        if (pick_owner == OWN_DATA) begin
                            bus_addr_q  <= data_addr;
                            bus_wdata_q <= data_wdata;
                            we_q        <= data_we;
                        end else begin
                            bus_addr_q  <= instr_addr;
                            bus_wdata_q <= '0;
                            we_q        <= 1'b0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus_busy) begin
                        bus_read_q  <= ~we_q;
                        bus_write_q <= we_q;
                        cnt_q       <= '0;
                        err_pend_q  <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (!bus_busy) begin
                        if (owner_q == OWN_DATA) begin
                            data_rdata_q <= bus_rdata;
                        end else begin
                            instr_rdata_q <= bus_rdata;
                        end
                        state_q <= DONE;
                    end else if (cnt_d == TIMEOUT_CNT) begin
                        err_pend_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    instr_ack_q  <= (owner_q == OWN_INSTR);
                    data_ack_q   <= (owner_q == OWN_DATA);
                    err_q        <= err_pend_q;
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ack   = instr_ack_q;
    assign instr_rdata = instr_rdata_q;
    assign data_ack    = data_ack_q;
    assign data_rdata  = data_rdata_q;
    assign err         = err_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_read    = bus_read_q;
    assign bus_write   = bus_write_q;
    assign grant_data  = (owner_q == OWN_DATA);

endmodule
